// File: rtl/tcp_tx_scheduler_pkg.sv
// tcp_tx_scheduler_pkg
//   Shared TCP transmit definitions: packet descriptor, scheduler FSM state
//   encoding and scheduler defaults.
package tcp_tx_scheduler_pkg;

  // Descriptor handed from a requester to the transmit engine.
  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [15:0] len;
  } tcp_packet_info_s;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tcp_tx_state_e;

  // Cycles allowed from sender_start until the engine raises busy.
  localparam int TCP_START_TIMEOUT_DEFAULT = 16;

  // Consecutive requester-0 grants tolerated while others wait.
  localparam int TCP_STARVE_LIMIT = 4;

endpackage

// File: rtl/tcp_rr_arbiter.sv
// tcp_rr_arbiter
//   Combinational round-robin selector. Picks the lowest-indexed request at
//   or above the pointer; if none, wraps to the lowest-indexed request.
// Ports:
//   req_i   - request vector
//   ptr_i   - index with highest priority this cycle
//   grant_o - one-hot grant (all zero when no request)
module tcp_rr_arbiter
  import tcp_tx_scheduler_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  logic [N-1:0] at_or_after;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign at_or_after[gi] = (gi >= int'(ptr_i));
    end
  endgenerate

  assign masked  = req_i & at_or_after;
  assign pick    = (|masked) ? masked : req_i;
  // Isolate the lowest set bit.
  assign grant_o = pick & (~pick + N'(1));

endmodule

// File: rtl/tcp_tx_scheduler.sv
// tcp_tx_scheduler
//   Arbitrates transmit requests (0 = control ACK/RST, 1 = new data,
//   2 = retransmit) onto a single transmit engine and tracks the launch /
//   completion handshake with it.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   req_valid     - per-requester request pending
//   req_info      - per-requester descriptor
//   req_ready     - one-hot accept pulse (combinational, IDLE only)
//   sender_start  - one-cycle launch pulse (START state)
//   sender_info   - descriptor of the last granted request
//   sender_busy   - engine busy
//   done_valid    - completion pulse on busy falling in WAIT_DONE
//   done_id       - requester index of the last grant
//   timeout_err   - sticky: engine failed to raise busy in time
//   active        - FSM not in IDLE
module tcp_tx_scheduler
  import tcp_tx_scheduler_pkg::*;
#(
  parameter int N_REQ         = 3,
  parameter int START_TIMEOUT = TCP_START_TIMEOUT_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_REQ-1:0]                     req_valid,
  input  tcp_packet_info_s [N_REQ-1:0]         req_info,
  output logic [N_REQ-1:0]                     req_ready,
  output logic                                 sender_start,
  output tcp_packet_info_s                     sender_info,
  input  logic                                 sender_busy,
  output logic                                 done_valid,
  output logic [$clog2(N_REQ)-1:0]             done_id,
  output logic                                 timeout_err,
  output logic                                 active
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int TO_W = $clog2(START_TIMEOUT + 1);

  tcp_tx_state_e    state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [2:0]       starve_q, starve_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d, to_cnt_inc;
  tcp_packet_info_s info_q, info_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic             timeout_err_q, timeout_err_d;

  logic [N_REQ-1:0] rr_req, rr_grant, win_onehot;
  logic [ID_W-1:0]  win_idx;
  logic             others_pending, force_rr, grant_en;

  // Requester 0 is handled by strict priority, so it never enters the ring.
  assign rr_req         = {req_valid[N_REQ-1:1], 1'b0};
  assign others_pending = |rr_req;

  tcp_rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (ID_W)
  ) u_rr (
    .req_i   (rr_req),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant)
  );

  // After the streak limit, requester 0 yields one grant to the ring.
  assign force_rr   = (starve_q >= 3'(TCP_STARVE_LIMIT)) && others_pending;
  assign win_onehot = (req_valid[0] && !force_rr) ? N_REQ'(1) : rr_grant;

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_onehot[k]) win_idx = ID_W'(k);
    end
  end

  // rst_n keeps req_ready quiet while reset is held with requests pending.
  assign grant_en = rst_n && (state_q == ST_IDLE) && !sender_busy && (|req_valid);

  // Counter tracks cycles since sender_start, saturating at the limit.
  assign to_cnt_inc = (to_cnt_q == TO_W'(START_TIMEOUT)) ? to_cnt_q
                                                         : to_cnt_q + TO_W'(1);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    starve_d      = starve_q;
    to_cnt_d      = to_cnt_q;
    info_d        = info_q;
    done_id_d     = done_id_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          state_d   = ST_START;
          info_d    = req_info[win_idx];
          done_id_d = win_idx;
          to_cnt_d  = '0;
          if (win_onehot[0]) begin
            // A requester-0 grant with nobody else waiting breaks the streak.
            starve_d = others_pending ? starve_q + 3'd1 : 3'd0;
          end else begin
            starve_d = 3'd0;
            ptr_d    = (win_idx == ID_W'(N_REQ - 1)) ? ID_W'(1) : win_idx + ID_W'(1);
          end
        end
      end
      ST_START: begin
        state_d  = ST_WAIT_BUSY;
        to_cnt_d = to_cnt_inc;
      end
      ST_WAIT_BUSY: begin
        to_cnt_d = to_cnt_inc;
        if (sender_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_inc == TO_W'(START_TIMEOUT)) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!sender_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= ID_W'(1);
      starve_q      <= '0;
      to_cnt_q      <= '0;
      info_q        <= '0;
      done_id_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      starve_q      <= starve_d;
      to_cnt_q      <= to_cnt_d;
      info_q        <= info_d;
      done_id_q     <= done_id_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready    = grant_en ? win_onehot : '0;
  assign sender_start = (state_q == ST_START);
  assign done_valid   = (state_q == ST_WAIT_DONE) && !sender_busy;
  assign active       = (state_q != ST_IDLE);
  assign sender_info  = info_q;
  assign done_id      = done_id_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_tcp_tx_scheduler.sv
// tb_tcp_tx_scheduler
//   Directed bench for tcp_tx_scheduler. Expected grant indices are queued
//   when a request pattern is driven and popped as each grant appears.
module tb_tcp_tx_scheduler;
  import tcp_tx_scheduler_pkg::*;

  localparam int N = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  tcp_packet_info_s [N-1:0] req_info;
  logic [N-1:0]         req_ready;
  logic                 sender_start;
  tcp_packet_info_s     sender_info;
  logic                 sender_busy;
  logic                 done_valid;
  logic [1:0]           done_id;
  logic                 timeout_err;
  logic                 active;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];
  int last_idx;
  int last_wait;

  always #5 clk = ~clk;

  tcp_tx_scheduler #(.N_REQ(N), .START_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_info     (req_info),
    .req_ready    (req_ready),
    .sender_start (sender_start),
    .sender_info  (sender_info),
    .sender_busy  (sender_busy),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .timeout_err  (timeout_err),
    .active       (active)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance cycle by cycle until req_ready pulses, then score the winner.
  task automatic wait_grant(input string tag);
    int  exp_idx;
    int  got;
    bit  seen;
    seen    = 1'b0;
    got     = -1;
    exp_idx = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    last_wait = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      last_wait++;
      if (req_ready != '0) seen = 1'b1;
    end
    check($sformatf("%s grant_seen", tag), 64'(seen), 64'(1));
    if (seen) begin
      for (int k = 0; k < N; k++) if (req_ready[k]) got = k;
      check($sformatf("%s winner", tag), 64'(got), 64'(exp_idx));
      check($sformatf("%s ready_onehot", tag), 64'($countones(req_ready)), 64'(1));
      check($sformatf("%s no_start_with_ready", tag), 64'(sender_start), 64'(0));
    end
    $display("txn %s: grant=%0d expected=%0d wait=%0d", tag, got, exp_idx, last_wait);
    last_idx = (exp_idx >= 0 && exp_idx < N) ? exp_idx : 0;
  endtask

  // Engine model: busy from the START cycle for busy_len cycles, then falls.
  task automatic serve(input string tag, input int busy_len, input int idx);
    @(negedge clk);
    sender_busy = 1'b1;
    #1;
    check($sformatf("%s start", tag), 64'(sender_start), 64'(1));
    check($sformatf("%s ready_low_at_start", tag), 64'(req_ready), 64'(0));
    check($sformatf("%s sender_info", tag), 64'(sender_info), 64'(req_info[idx]));
    check($sformatf("%s done_id_latched", tag), 64'(done_id), 64'(idx));
    for (int c = 1; c < busy_len; c++) begin
      @(negedge clk); #1;
      check($sformatf("%s no_early_done", tag), 64'(done_valid), 64'(0));
    end
    @(negedge clk);
    sender_busy = 1'b0;
    #1;
    check($sformatf("%s done_valid", tag), 64'(done_valid), 64'(1));
    check($sformatf("%s done_id", tag), 64'(done_id), 64'(idx));
    $display("txn %s: done id=%0d", tag, done_id);
  endtask

  task automatic apply_after_posedge(input logic [N-1:0] v);
    @(posedge clk); #2;
    req_valid = v;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_info[i].seq   = 32'hA000_0000 + 32'(i);
      req_info[i].ack   = 32'h0B00_0000 + 32'(i * 7);
      req_info[i].flags = 8'h10 + 8'(i);
      req_info[i].len   = 16'd100 + 16'(i);
    end
    rst_n       = 1'b0;
    req_valid   = 3'b001;
    sender_busy = 1'b0;

    // Reset state, with a request pending that must not be accepted.
    repeat (2) @(negedge clk);
    #1;
    check("rst req_ready", 64'(req_ready), 64'(0));
    check("rst sender_start", 64'(sender_start), 64'(0));
    check("rst done_valid", 64'(done_valid), 64'(0));
    check("rst timeout_err", 64'(timeout_err), 64'(0));
    check("rst active", 64'(active), 64'(0));
    check("rst sender_info", 64'(sender_info), 64'(0));
    check("rst done_id", 64'(done_id), 64'(0));
    $display("txn reset: checked");
    req_valid = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Requester 0 idle, 1 and 2 held: round-robin alternation.
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2);
    apply_after_posedge(3'b110);
    for (int t = 0; t < 4; t++) begin
      wait_grant($sformatf("rr110_%0d", t));
      if (t > 0) check("rr110 spacing", 64'(last_wait), 64'(1));
      serve($sformatf("rr110_%0d", t), 2, last_idx);
    end
    req_valid = '0;

    // Single new-data request, engine busy for 10 cycles.
    exp_q.push_back(1);
    apply_after_posedge(3'b010);
    wait_grant("single1");
    check("single1 ready_vec", 64'(req_ready), 64'(3'b010));
    serve("single1", 10, last_idx);
    req_valid = '0;

    // Engine busy while idle: no grant until busy drops.
    @(posedge clk); #2;
    sender_busy = 1'b1;
    req_valid   = 3'b001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("busyidle no_grant", 64'(req_ready), 64'(0));
      check("busyidle active", 64'(active), 64'(0));
    end
    $display("txn busyidle: held off 5 cycles");
    exp_q.push_back(0);
    @(posedge clk); #2;
    sender_busy = 1'b0;
    wait_grant("busyidle");
    check("busyidle immediate", 64'(last_wait), 64'(1));
    serve("busyidle", 3, last_idx);
    req_valid = '0;

    // Reset in WAIT_DONE: transfer dropped, request re-granted afterwards.
    exp_q.push_back(2);
    apply_after_posedge(3'b100);
    wait_grant("rstmid");
    @(negedge clk);
    sender_busy = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("rstmid in_wait_done", 64'(active), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rstmid active", 64'(active), 64'(0));
    check("rstmid done_valid", 64'(done_valid), 64'(0));
    check("rstmid req_ready", 64'(req_ready), 64'(0));
    check("rstmid sender_info", 64'(sender_info), 64'(0));
    @(negedge clk);
    sender_busy = 1'b0;
    #1;
    check("rstmid no_done", 64'(done_valid), 64'(0));
    $display("txn rstmid: reset applied");
    exp_q.push_back(2);
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_grant("rstmid_regrant");
    check("rstmid regrant_immediate", 64'(last_wait), 64'(1));
    serve("rstmid_regrant", 2, last_idx);
    req_valid = '0;

    // All three held: four control grants, then one ring grant.
    begin
      int seq_exp[15];
      seq_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1};
      for (int t = 0; t < 15; t++) exp_q.push_back(seq_exp[t]);
    end
    apply_after_posedge(3'b111);
    for (int t = 0; t < 15; t++) begin
      wait_grant($sformatf("prio111_%0d", t));
      if (t > 0) check("prio111 spacing", 64'(last_wait), 64'(1));
      serve($sformatf("prio111_%0d", t), 2, last_idx);
    end
    req_valid = '0;
    check("scoreboard drained", 64'(exp_q.size()), 64'(0));

    // Engine never raises busy: timeout 16 cycles after sender_start.
    exp_q.push_back(0);
    apply_after_posedge(3'b001);
    wait_grant("timeout");
    @(negedge clk); #1;
    check("timeout start", 64'(sender_start), 64'(1));
    req_valid = '0;
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk); #1;
      check("timeout err_low", 64'(timeout_err), 64'(0));
      check("timeout active", 64'(active), 64'(1));
      check("timeout no_done", 64'(done_valid), 64'(0));
    end
    @(negedge clk); #1;
    check("timeout err_set", 64'(timeout_err), 64'(1));
    check("timeout idle", 64'(active), 64'(0));
    check("timeout no_done_at_exit", 64'(done_valid), 64'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check("timeout sticky", 64'(timeout_err), 64'(1));
      check("timeout no_late_done", 64'(done_valid), 64'(0));
      check("timeout info_held", 64'(sender_info), 64'(req_info[0]));
    end
    $display("txn timeout: err=%0d", timeout_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
